stereo_processor: RTL and testbench

Downstream of the reorder assembler. It consumes the four per-granule/per-channel coefficient streams, one coefficient index per valid cycle. When the frame is joint stereo with MS enabled, it applies mid/side reconstruction: L = (M+S)/√2, R = (M−S)/√2. Otherwise it passes the data through unchanged. Output is a 3-cycle pipeline carrying the coefficient index and a frame-done pulse to the alias-reduction/IMDCT stage.

---
 rtl/stereo_processor.sv | 224 ++++++++++++++++++++++
 tb/tb_stereo_processor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_processor.sv
// stereo_processor: mid/side reconstruction (or passthrough) of the four
// per-granule/per-channel coefficient streams feeding alias reduction/IMDCT.
//
// Handshake: d_valid_in qualifies the four coefficient inputs for exactly one
// cycle. There is no ready; the block takes one sample per cycle at full
// rate. d_valid_out marks the cycle in which l_*/r_*/idx_out carry a result.
// frame_done is asserted only together with the idx 575 result.
module stereo_processor #(
  parameter int                 NUM_SAMPLES = 576,
  parameter logic signed [31:0] INV_SQRT2   = 32'h2D413CCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame_start,
  input  logic [1:0]  mode,
  input  logic [1:0]  mode_ext,
  input  logic [31:0] ch1_gr1_in,
  input  logic [31:0] ch2_gr1_in,
  input  logic [31:0] ch1_gr2_in,
  input  logic [31:0] ch2_gr2_in,
  input  logic        d_valid_in,
  output logic [31:0] l_gr1_out,
  output logic [31:0] r_gr1_out,
  output logic [31:0] l_gr2_out,
  output logic [31:0] r_gr2_out,
  output logic [9:0]  idx_out,
  output logic        d_valid_out,
  output logic        frame_done,
  output logic [1:0]  state_dbg
);

  localparam logic [9:0] LAST_IDX = 10'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t     state, next_state;
  logic [9:0] count, next_count;
  logic       ms_en, next_ms_en;
  logic       accept;

  // Intensity stereo is not handled; its mode bit is intentionally ignored.
  logic unused_is_bit;
  assign unused_is_bit = mode_ext[0];

  assign state_dbg = state;

  // Frame control registers: state, input index counter and latched MS flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      count <= 10'd0;
      ms_en <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      ms_en <= next_ms_en;
    end
  end

  // Next-state logic; a frame start wins over a same-cycle valid.
  always_comb begin
    next_state = state;
    next_count = count;
    next_ms_en = ms_en;
    accept     = 1'b0;
    if (new_frame_start) begin
      next_ms_en = (mode == 2'b01) && mode_ext[1];
      next_count = 10'd0;
      next_state = S_STREAM;
    end else begin
      case (state)
        S_STREAM: begin
          if (d_valid_in) begin
            accept = 1'b1;
            if (count == LAST_IDX) begin
              next_count = 10'd0;
              next_state = S_DONE;
            end else begin
              next_count = count + 10'd1;
            end
          end
        end
        default: begin
          next_state = state;
        end
      endcase
    end
  end

  // Index 0 = granule 1, index 1 = granule 2.
  logic signed [31:0] m_in [2];
  logic signed [31:0] s_in [2];
  assign m_in[0] = ch1_gr1_in;
  assign s_in[0] = ch2_gr1_in;
  assign m_in[1] = ch1_gr2_in;
  assign s_in[1] = ch2_gr2_in;

  logic signed [32:0] sum_c  [2];
  logic signed [32:0] diff_c [2];

  // Stage 1 arithmetic: M+S / M-S when MS is active, otherwise the raw channels.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      sum_c[g]  = 33'(m_in[g]);
      diff_c[g] = 33'(s_in[g]);
      if (ms_en) begin
        sum_c[g]  = 33'(m_in[g]) + 33'(s_in[g]);
        diff_c[g] = 33'(m_in[g]) - 33'(s_in[g]);
      end
    end
  end

  logic               s1_valid;
  logic               s1_ms;
  logic [9:0]         s1_idx;
  logic signed [32:0] s1_sum  [2];
  logic signed [32:0] s1_diff [2];

  // Stage 1 register: captures the accepted sample with its index and MS tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ms    <= 1'b0;
      s1_idx   <= 10'd0;
      for (int g = 0; g < 2; g++) begin
        s1_sum[g]  <= '0;
        s1_diff[g] <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ms  <= ms_en;
        s1_idx <= count;
        for (int g = 0; g < 2; g++) begin
          s1_sum[g]  <= sum_c[g];
          s1_diff[g] <= diff_c[g];
        end
      end
    end
  end

  logic signed [64:0] psum_c  [2];
  logic signed [64:0] pdiff_c [2];

  // Stage 2 arithmetic: scale by 1/sqrt(2) in Q1.30, or pre-shift the raw
  // value left by 30 so the common stage-3 shift returns it unchanged.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      psum_c[g]  = {{2{s1_sum[g][32]}}, s1_sum[g], 30'd0};
      pdiff_c[g] = {{2{s1_diff[g][32]}}, s1_diff[g], 30'd0};
      if (s1_ms) begin
        psum_c[g]  = 65'(s1_sum[g]) * 65'(INV_SQRT2);
        pdiff_c[g] = 65'(s1_diff[g]) * 65'(INV_SQRT2);
      end
    end
  end

  logic               s2_valid;
  logic [9:0]         s2_idx;
  logic signed [64:0] s2_sum  [2];
  logic signed [64:0] s2_diff [2];

  // Stage 2 register: products (or carried operands) with index and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_idx   <= 10'd0;
      for (int g = 0; g < 2; g++) begin
        s2_sum[g]  <= '0;
        s2_diff[g] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        for (int g = 0; g < 2; g++) begin
          s2_sum[g]  <= psum_c[g];
          s2_diff[g] <= pdiff_c[g];
        end
      end
    end
  end

  // Arithmetic shift by 30 (floor) then clamp to the signed 32-bit range.
  function automatic logic [31:0] sat_shift(input logic signed [64:0] v);
    logic signed [64:0] sh;
    sh = v >>> 30;
    if (sh[64:31] == {34{sh[31]}}) begin
      sat_shift = sh[31:0];
    end else if (sh[64]) begin
      sat_shift = 32'h8000_0000;
    end else begin
      sat_shift = 32'h7FFF_FFFF;
    end
  endfunction

  // Stage 3 register: rescale/saturate and drive the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_gr1_out   <= 32'd0;
      r_gr1_out   <= 32'd0;
      l_gr2_out   <= 32'd0;
      r_gr2_out   <= 32'd0;
      idx_out     <= 10'd0;
      d_valid_out <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      d_valid_out <= s2_valid;
      frame_done  <= s2_valid && (s2_idx == LAST_IDX);
      if (s2_valid) begin
        idx_out   <= s2_idx;
        l_gr1_out <= sat_shift(s2_sum[0]);
        r_gr1_out <= sat_shift(s2_diff[0]);
        l_gr2_out <= sat_shift(s2_sum[1]);
        r_gr2_out <= sat_shift(s2_diff[1]);
      end
    end
  end

endmodule

// File: tb/tb_stereo_processor.sv
// Testbench for stereo_processor: directed corners plus randomized frames,
// checked every cycle against a behavioural model with a timed expected queue.
module tb_stereo_processor;

  localparam int     N = 576;
  localparam longint C = 759250125; // 0x2D413CCD, 1/sqrt(2) in Q1.30

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_frame_start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [1:0]  mode_ext = 2'b00;
  logic [31:0] ch1_gr1_in = '0, ch2_gr1_in = '0, ch1_gr2_in = '0, ch2_gr2_in = '0;
  logic        d_valid_in = 1'b0;
  logic [31:0] l_gr1_out, r_gr1_out, l_gr2_out, r_gr2_out;
  logic [9:0]  idx_out;
  logic        d_valid_out, frame_done;
  logic [1:0]  state_dbg;

  stereo_processor dut (
    .clk(clk), .rst(rst), .new_frame_start(new_frame_start),
    .mode(mode), .mode_ext(mode_ext),
    .ch1_gr1_in(ch1_gr1_in), .ch2_gr1_in(ch2_gr1_in),
    .ch1_gr2_in(ch1_gr2_in), .ch2_gr2_in(ch2_gr2_in),
    .d_valid_in(d_valid_in),
    .l_gr1_out(l_gr1_out), .r_gr1_out(r_gr1_out),
    .l_gr2_out(l_gr2_out), .r_gr2_out(r_gr2_out),
    .idx_out(idx_out), .d_valid_out(d_valid_out), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] sat_floor(input longint prod);
    longint q;
    q = prod >>> 30;
    if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (q < -64'sd2147483648) return 32'h8000_0000;
    return q[31:0];
  endfunction

  task automatic ms_calc(input logic [31:0] m, input logic [31:0] s, input bit ms,
                         output logic [31:0] l, output logic [31:0] r);
    longint mm, ss;
    mm = longint'($signed(m));
    ss = longint'($signed(s));
    if (ms) begin
      l = sat_floor((mm + ss) * C);
      r = sat_floor((mm - ss) * C);
    end else begin
      l = m;
      r = s;
    end
  endtask

  typedef struct packed {
    int          due;
    logic [31:0] l1, r1, l2, r2;
    logic [9:0]  idx;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   m_phase = 0;   // 0 idle, 1 streaming, 2 frame complete
  int   m_count = 0;
  bit   m_ms = 1'b0;

  // Model: decide acceptance from the frame rules and schedule the result
  // to appear after the third clock edge counting the accepting edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_phase = 0;
      m_count = 0;
      m_ms    = 1'b0;
    end else if (new_frame_start) begin
      m_ms    = (mode == 2'b01) && mode_ext[1];
      m_count = 0;
      m_phase = 1;
    end else if (m_phase == 1 && d_valid_in) begin
      ms_calc(ch1_gr1_in, ch2_gr1_in, m_ms, e.l1, e.r1);
      ms_calc(ch1_gr2_in, ch2_gr2_in, m_ms, e.l2, e.r2);
      e.due  = cyc + 2;
      e.idx  = 10'(m_count);
      e.done = (m_count == N - 1);
      exp_q.push_back(e);
      if (m_count == N - 1) begin
        m_count = 0;
        m_phase = 2;
      end else begin
        m_count++;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  int out_count = 0;
  int done_count = 0;
  int last_done_idx = -1;

  always @(negedge clk) begin
    exp_t e;
    if (rst && d_valid_out) out_count++;
    if (rst && frame_done) begin
      done_count++;
      last_done_idx = int'(idx_out);
    end
    if (!rst) begin
      check("rst_valid", 64'(d_valid_out), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_idx", 64'(idx_out), 64'd0);
      check("rst_l1", 64'(l_gr1_out), 64'd0);
      check("rst_r1", 64'(r_gr1_out), 64'd0);
      check("rst_l2", 64'(l_gr2_out), 64'd0);
      check("rst_r2", 64'(r_gr2_out), 64'd0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("sb_valid", 64'(d_valid_out), 64'd1);
      check("sb_done", 64'(frame_done), 64'(e.done));
      check("sb_idx", 64'(idx_out), 64'(e.idx));
      check("sb_l1", 64'(l_gr1_out), 64'(e.l1));
      check("sb_r1", 64'(r_gr1_out), 64'(e.r1));
      check("sb_l2", 64'(l_gr2_out), 64'(e.l2));
      check("sb_r2", 64'(r_gr2_out), 64'(e.r2));
    end else begin
      check("sb_no_valid", 64'(d_valid_out), 64'd0);
      check("sb_no_done", 64'(frame_done), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input bit v);
    ch1_gr1_in = a;
    ch2_gr1_in = b;
    ch1_gr2_in = c;
    ch2_gr2_in = d;
    d_valid_in = v;
    tick();
    d_valid_in = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] md, input logic [1:0] ext, input bit with_valid);
    mode            = md;
    mode_ext        = ext;
    new_frame_start = 1'b1;
    d_valid_in      = with_valid;
    ch1_gr1_in      = $urandom;
    ch2_gr1_in      = $urandom;
    ch1_gr2_in      = $urandom;
    ch2_gr2_in      = $urandom;
    tick();
    new_frame_start = 1'b0;
    d_valid_in      = 1'b0;
  endtask

  function automatic logic [31:0] rand_coef();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 4095)) - 32'd2048;
      default: return $urandom;
    endcase
  endfunction

  // Wait (bounded) for the next output and compare it with literal values.
  task automatic wait_lit(input string name, input logic [31:0] l1, input logic [31:0] r1,
                          input logic [31:0] l2, input logic [31:0] r2, input logic [9:0] idx);
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d_valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({name, "_l1"}, 64'(l_gr1_out), 64'(l1));
      check({name, "_r1"}, 64'(r_gr1_out), 64'(r1));
      check({name, "_l2"}, 64'(l_gr2_out), 64'(l2));
      check({name, "_r2"}, 64'(r_gr2_out), 64'(r2));
      check({name, "_idx"}, 64'(idx_out), 64'(idx));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv, sent;

    // Reset held with random activity on every input.
    for (int i = 0; i < 5; i++) begin
      new_frame_start = 1'($urandom);
      mode            = 2'($urandom);
      mode_ext        = 2'($urandom);
      drive($urandom, $urandom, $urandom, $urandom, 1'($urandom));
    end
    new_frame_start = 1'b0;
    check("rst_state_idle", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    tick();
    tick();

    // Frame start with a coincident valid: that sample must be dropped.
    start_frame(2'b01, 2'b10, 1'b1);
    repeat (4) tick();
    check("nfs_no_output", 64'(out_count), 64'd0);
    check("nfs_state_stream", 64'(state_dbg), 64'd1);

    // Mid/side math and saturation.
    drive(32'h0100_0000, 32'h0, 32'h0, 32'h0100_0000, 1'b1);
    wait_lit("ms_basic", 32'h00B5_04F3, 32'h00B5_04F3, 32'h00B5_04F3, 32'hFF4A_FB0C, 10'd0);
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_lit("ms_sat", 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 10'd1);

    // Passthrough.
    start_frame(2'b00, 2'b10, 1'b0);
    drive(32'h1234_5678, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321, 1'b1);
    wait_lit("pass", 32'h1234_5678, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321, 10'd0);

    // Mode change while two MS samples are in flight.
    start_frame(2'b01, 2'b10, 1'b0);
    drive(32'h0100_0000, 32'h0, 32'h0, 32'h0100_0000, 1'b1);
    drive(32'h0040_0000, 32'h0040_0000, 32'h0, 32'h0, 1'b1);
    start_frame(2'b00, 2'b10, 1'b0);
    wait_lit("inflight0", 32'h00B5_04F3, 32'h00B5_04F3, 32'h00B5_04F3, 32'hFF4A_FB0C, 10'd0);
    wait_lit("inflight1", 32'h005A_8279, 32'h0, 32'h0, 32'h0, 10'd1);
    drive(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    wait_lit("pass_after", 32'd1, 32'd2, 32'd3, 32'd4, 10'd0);

    // Full frame of 576 consecutive valids, then one extra.
    start_frame(2'b00, 2'b00, 1'b0);
    repeat (4) tick();
    out_count = 0;
    done_count = 0;
    last_done_idx = -1;
    for (int i = 0; i < N; i++) drive(32'(i), ~32'(i), 32'(i), 32'(i) + 32'd7, 1'b1);
    drive(32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 1'b1);
    repeat (6) tick();
    check("full_out_count", 64'(out_count), 64'd576);
    check("full_done_count", 64'(done_count), 64'd1);
    check("full_done_idx", 64'(last_done_idx), 64'd575);
    check("full_state_done", 64'(state_dbg), 64'd2);

    // Restart after a completed frame begins again at index 0.
    start_frame(2'b00, 2'b00, 1'b0);
    drive(32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
    wait_lit("restart", 32'd5, 32'd6, 32'd7, 32'd8, 10'd0);

    // Randomized frames: random mode, gaps, short/over-long frames, and
    // mode inputs wiggling between frame starts.
    for (int f = 0; f < 5; f++) begin
      start_frame(2'($urandom), 2'($urandom), 1'($urandom));
      case ($urandom_range(0, 2))
        0: nv = N;
        1: nv = N + 20;
        default: nv = $urandom_range(50, 500);
      endcase
      sent = 0;
      while (sent < nv) begin
        mode     = 2'($urandom);
        mode_ext = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          drive(rand_coef(), rand_coef(), rand_coef(), rand_coef(), 1'b0);
        end else begin
          drive(rand_coef(), rand_coef(), rand_coef(), rand_coef(), 1'b1);
          sent++;
        end
      end
      repeat (5) tick();
    end

    // Asynchronous reset at sample 300 flushes everything.
    start_frame(2'b01, 2'b10, 1'b0);
    for (int i = 0; i < 300; i++) drive(rand_coef(), rand_coef(), rand_coef(), rand_coef(), 1'b1);
    ch1_gr1_in = $urandom;
    d_valid_in = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_count = 0;
    for (int i = 0; i < 3; i++) drive(rand_coef(), rand_coef(), rand_coef(), rand_coef(), 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) drive(rand_coef(), rand_coef(), rand_coef(), rand_coef(), 1'b1);
    repeat (4) tick();
    check("rst_mid_no_output", 64'(out_count), 64'd0);
    check("rst_mid_state_idle", 64'(state_dbg), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
